// File: rtl/binary_window_conv_if.sv
`default_nettype none
// ============================================================================
//  Module   : binary_window_conv_if
//  Brief    : Frame-control, window-input and output-RAM signals of the
//             binary convolution stage, grouped into one bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface binary_window_conv_if #(
   parameter int KK             = 9,
   parameter int PC_W           = 4,
   parameter int OUT_ADDR_WIDTH = 10
);
   logic                      start;
   logic [KK-1:0]             weights;
   logic [PC_W-1:0]           threshold;
   logic [KK-1:0]             win_in;
   logic                      win_valid;
   logic                      slide;
   logic [OUT_ADDR_WIDTH-1:0] out_addr;
   logic                      out_data;
   logic                      out_wen;
   logic                      busy;
   logic                      done;

   // Upstream / controlling side: drives frame control and windows.
   modport master (
      output start, weights, threshold, win_in, win_valid,
      input  slide, out_addr, out_data, out_wen, busy, done
   );

   // Convolution stage side.
   modport slave (
      input  start, weights, threshold, win_in, win_valid,
      output slide, out_addr, out_data, out_wen, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/binary_window_conv.sv
`default_nettype none
// ============================================================================
//  Module   : binary_window_conv
//  Brief    : Binary (XNOR / popcount / threshold) convolution stage. Accepts
//             one window per rising edge of win_valid, writes one feature bit
//             per window to sequential output RAM addresses, and requests the
//             next window with a one-cycle slide pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module binary_window_conv #(
   parameter int IMAGE_ROW_LEN  = 32,
   parameter int IMAGE_COL_LEN  = 32,
   parameter int KERNEL_SIZE    = 3,
   parameter int STRIDE         = 1,
   parameter int OUT_ADDR_WIDTH = 10,
   parameter int PC_W           = $clog2(KERNEL_SIZE*KERNEL_SIZE+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   binary_window_conv_if.slave  bus
);

   localparam int KK       = KERNEL_SIZE*KERNEL_SIZE;
   localparam int OUT_ROWS = (IMAGE_ROW_LEN-KERNEL_SIZE)/STRIDE+1;
   localparam int OUT_COLS = (IMAGE_COL_LEN-KERNEL_SIZE)/STRIDE+1;
   localparam int N        = OUT_ROWS*OUT_COLS;
   localparam int CNT_W    = $clog2(N+1);
   localparam logic [CNT_W-1:0] C_N = CNT_W'(N);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_WIN = 2'd1,
      S_REQ      = 2'd2,
      S_FLUSH    = 2'd3
   } state_t;

   state_t                    state_q;
   logic [KK-1:0]             weights_q;
   logic [PC_W-1:0]           threshold_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      slide_q;

   logic                      win_valid_q;
   logic                      s1_valid_q;
   logic [KK-1:0]             s1_xnor_q;
   logic                      s2_valid_q;
   logic [PC_W-1:0]           s2_pc_q;
   logic                      out_wen_q;
   logic                      out_data_q;
   logic [OUT_ADDR_WIDTH-1:0] out_addr_q;

   logic                      accept_d;
   logic                      start_ok_d;
   logic [KK-1:0]             xnor_d;
   logic [PC_W-1:0]           pc_d;
   logic                      fire_d;
   logic [CNT_W-1:0]          cnt_inc_d;

   // Window edge detection, start qualification and per-stage datapath math
   always_comb begin
      accept_d   = bus.win_valid & ~win_valid_q & (state_q == S_WAIT_WIN);
      start_ok_d = bus.start & (state_q == S_IDLE);
      xnor_d     = ~(bus.win_in ^ weights_q);
      cnt_inc_d  = cnt_q + 1'b1;
      fire_d     = (s2_pc_q >= threshold_q);
      pc_d       = '0;
      for (int i = 0; i < KK; i++) begin
         pc_d = pc_d + PC_W'(s1_xnor_q[i]);
      end
   end

   // Frame controller: kernel latch, window counting, slide requests, drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         weights_q   <= '0;
         threshold_q <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         slide_q     <= 1'b0;
      end else begin
         slide_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok_d) begin
                  weights_q   <= bus.weights;
                  threshold_q <= bus.threshold;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_WAIT_WIN;
               end
            end
            S_WAIT_WIN: begin
               if (accept_d) begin
                  cnt_q <= cnt_inc_d;
                  if (cnt_inc_d == C_N) begin
                     state_q <= S_FLUSH;
                  end else begin
                     slide_q <= 1'b1;
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               state_q <= S_WAIT_WIN;
            end
            S_FLUSH: begin
               // The last result sits in the output stage when S1/S2 are
               // empty, so done lands the cycle right after the final write.
               if (!s1_valid_q && !s2_valid_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // XNOR -> popcount -> threshold pipeline and output address tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_xnor_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_pc_q     <= '0;
         out_wen_q   <= 1'b0;
         out_data_q  <= 1'b0;
         out_addr_q  <= '0;
      end else begin
         win_valid_q <= bus.win_valid;
         s1_valid_q  <= accept_d;
         if (accept_d) begin
            s1_xnor_q <= xnor_d;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_pc_q <= pc_d;
         end
         out_wen_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_data_q <= fire_d;
         end
         if (start_ok_d) begin
            out_addr_q <= '0;
         end else if (out_wen_q) begin
            out_addr_q <= out_addr_q + 1'b1;
         end
      end
   end

   assign bus.slide    = slide_q;
   assign bus.out_addr = out_addr_q;
   assign bus.out_data = out_data_q;
   assign bus.out_wen  = out_wen_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_window_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_window_conv
//  Brief    : Self-checking bench for binary_window_conv on a 4x4 image with
//             a 3x3 kernel (four windows per frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_binary_window_conv;

   localparam int KK   = 9;
   localparam int PC_W = 4;
   localparam int AW   = 10;
   localparam int NWIN = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   binary_window_conv_if #(.KK(KK), .PC_W(PC_W), .OUT_ADDR_WIDTH(AW)) bus ();

   binary_window_conv #(
      .IMAGE_ROW_LEN (4),
      .IMAGE_COL_LEN (4),
      .KERNEL_SIZE   (3),
      .STRIDE        (1),
      .OUT_ADDR_WIDTH(AW),
      .PC_W          (PC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [KK-1:0]        w;
      logic [PC_W-1:0]      thr;
      logic [3:0][KK-1:0]   win;
      logic [3:0]           exp;
   } frame_t;

   typedef struct {
      logic          d;
      logic [AW-1:0] a;
      int            c;
   } sb_t;

   sb_t sb[$];
   int  chk_cnt   = 0;
   int  pass_cnt  = 0;
   int  cyc       = 0;
   int  wen_cnt   = 0;
   int  slide_cnt = 0;
   int  done_cnt  = 0;
   int  exp_addr  = 0;
   logic prev_wen = 1'b0;
   frame_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic frame_t mk(input logic [KK-1:0] w, input logic [PC_W-1:0] thr,
                                 input logic [KK-1:0] w0, input logic [KK-1:0] w1,
                                 input logic [KK-1:0] w2, input logic [KK-1:0] w3,
                                 input logic e0, input logic e1, input logic e2, input logic e3);
      frame_t f;
      f.w   = w;
      f.thr = thr;
      f.win = {w3, w2, w1, w0};
      f.exp = {e3, e2, e1, e0};
      return f;
   endfunction

   // Observes outputs half a cycle after each active edge
   task automatic monitor();
      sb_t e;
      if (bus.out_wen) begin
         check("wen_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_data", bus.out_data, e.d);
            check("out_addr", bus.out_addr, e.a);
            check("wen_latency", cyc, e.c);
         end
         wen_cnt++;
      end
      if (bus.slide) slide_cnt++;
      if (bus.done) begin
         done_cnt++;
         check("done_after_wen", prev_wen, 1);
         check("done_wen_count", wen_cnt, NWIN);
      end
      prev_wen = bus.out_wen;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_slide"},    bus.slide,    0);
      check({tag, "_out_wen"},  bus.out_wen,  0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_busy"},     bus.busy,     0);
      check({tag, "_done"},     bus.done,     0);
      check({tag, "_out_addr"}, bus.out_addr, 0);
   endtask

   task automatic do_start(input logic [KK-1:0] w, input logic [PC_W-1:0] thr);
      wen_cnt   = 0;
      slide_cnt = 0;
      exp_addr  = 0;
      bus.start     = 1'b1;
      bus.weights   = w;
      bus.threshold = thr;
      tick();
      bus.start     = 1'b0;
      // Scramble the kernel inputs so only the latched copy is meaningful.
      bus.weights   = ~w;
      bus.threshold = ~thr;
      check("busy_after_start", bus.busy, 1);
   endtask

   task automatic send_window(input logic [KK-1:0] win, input logic e, input int hold, input logic last);
      sb_t ent;
      int  s0;
      ent.d = e;
      ent.a = exp_addr[AW-1:0];
      ent.c = cyc + 3;
      sb.push_back(ent);
      exp_addr++;
      s0 = slide_cnt;
      bus.win_in    = win;
      bus.win_valid = 1'b1;
      tick();
      check("slide_timing", bus.slide, !last);
      repeat (hold - 1) tick();
      bus.win_valid = 1'b0;
      bus.win_in    = KK'($urandom);
      tick();
      check("slide_count", slide_cnt - s0, last ? 0 : 1);
   endtask

   task automatic wait_done();
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 20) begin
         tick();
         n++;
      end
      check("done_seen", done_cnt - d0, 1);
      check("busy_after_done", bus.busy, 0);
      check("frame_writes", wen_cnt, NWIN);
      check("frame_slides", slide_cnt, NWIN - 1);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int d_before;
      tbl[0] = mk(9'h1FF, 4'd5,  9'h1FF, 9'h00F, 9'h0F0, 9'h1F0, 1, 0, 0, 1);
      tbl[1] = mk(9'h000, 4'd5,  9'h000, 9'h1FF, 9'h01F, 9'h03F, 1, 0, 0, 0);
      tbl[2] = mk(9'h0AA, 4'd0,  9'h123, 9'h000, 9'h1FF, 9'h055, 1, 1, 1, 1);
      tbl[3] = mk(9'h0AA, 4'd10, 9'h0AA, 9'h155, 9'h1FF, 9'h000, 0, 0, 0, 0);
      tbl[4] = mk(9'h155, 4'd9,  9'h155, 9'h154, 9'h0AA, 9'h155, 1, 0, 0, 1);
      tbl[5] = mk(9'h1FF, 4'd1,  9'h001, 9'h000, 9'h100, 9'h1FF, 1, 0, 1, 1);

      bus.start     = 1'b0;
      bus.weights   = '0;
      bus.threshold = '0;
      bus.win_in    = '0;
      bus.win_valid = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Table-driven frames
      for (int f = 0; f < 6; f++) begin
         do_start(tbl[f].w, tbl[f].thr);
         for (int i = 0; i < NWIN; i++) begin
            send_window(tbl[f].win[i], tbl[f].exp[i], 1, i == NWIN - 1);
         end
         wait_done();
      end

      // win_valid held high for several cycles counts as one window
      do_start(9'h1FF, 4'd5);
      send_window(9'h1FF, 1'b1, 4, 1'b0);
      check("held_one_write", wen_cnt, 1);
      send_window(9'h00F, 1'b0, 1, 1'b0);
      send_window(9'h0F0, 1'b0, 1, 1'b0);
      send_window(9'h1F0, 1'b1, 1, 1'b1);
      wait_done();

      // start and stray win_valid edge while busy are ignored
      do_start(9'h1FF, 4'd5);
      send_window(9'h1FF, 1'b1, 1, 1'b0);
      bus.start     = 1'b1;
      bus.weights   = 9'h000;
      bus.threshold = 4'd0;
      tick();
      bus.start = 1'b0;
      check("busy_mid_frame", bus.busy, 1);
      send_window(9'h00F, 1'b0, 1, 1'b0);
      send_window(9'h0F0, 1'b0, 1, 1'b0);
      send_window(9'h1F0, 1'b1, 1, 1'b1);
      bus.win_valid = 1'b1;
      tick();
      bus.win_valid = 1'b0;
      wait_done();
      bus.win_valid = 1'b1;
      tick();
      bus.win_valid = 1'b0;
      repeat (6) tick();
      check("idle_edge_no_write", wen_cnt, NWIN);
      check("idle_edge_no_busy", bus.busy, 0);

      // Asynchronous reset mid-frame discards the in-flight result
      do_start(9'h1FF, 4'd5);
      send_window(9'h1FF, 1'b1, 1, 1'b0);
      send_window(9'h00F, 1'b0, 1, 1'b0);
      send_window(9'h0F0, 1'b0, 1, 1'b0);
      check("pre_reset_writes", wen_cnt, 2);
      d_before = done_cnt;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (8) tick();
      check("post_reset_writes", wen_cnt, 2);
      check("post_reset_no_done", done_cnt - d_before, 0);

      // Fresh frame after reset restarts at address 0
      do_start(tbl[0].w, tbl[0].thr);
      for (int i = 0; i < NWIN; i++) begin
         send_window(tbl[0].win[i], tbl[0].exp[i], 1, i == NWIN - 1);
      end
      wait_done();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
